// File: rtl/debug_pkg.sv
// Shared definitions for the KS10 debug/trace unit: trace mode codes,
// FSM state codes and the debug word packing helper.
package debug_pkg;

  localparam logic [1:0] TR_OFF   = 2'b00;
  localparam logic [1:0] TR_CONT  = 2'b01;
  localparam logic [1:0] TR_START = 2'b10;
  localparam logic [1:0] TR_STOP  = 2'b11;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_ARMED = 3'd1,
    ST_ACQ   = 3'd2,
    ST_POST  = 3'd3,
    ST_DONE  = 3'd4
  } tr_state_e;

  function automatic logic [63:0] pack_itr(input logic [17:0] pc, input logic [35:0] hr);
    return {10'b0, pc, hr};
  endfunction

endpackage

// File: rtl/trace_ram.sv
// Simple dual-port trace RAM: one write port, one registered read port.
// The read register is read-first, so a same-address write returns the old entry.
module trace_ram #(
  parameter int DEPTH = 1024,
  parameter int WIDTH = 54
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     we,
  input  logic [$clog2(DEPTH)-1:0] waddr,
  input  logic [WIDTH-1:0]         wdata,
  input  logic                     re,
  input  logic [$clog2(DEPTH)-1:0] raddr,
  output logic [WIDTH-1:0]         rdata
);

  logic [WIDTH-1:0] mem_r [DEPTH];

  // Storage array write port
  always_ff @(posedge clk) begin
    if (we) begin
      mem_r[waddr] <= wdata;
    end
  end

  // Registered read port, holds its value when no read is requested
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rdata <= {WIDTH{1'b0}};
    end else if (re) begin
      rdata <= mem_r[raddr];
    end
  end

endmodule

// File: rtl/debug_trace.sv
// KS10 breakpoint and instruction-trace unit: NBRK masked address comparators
// with sticky halt, plus a DEPTH-entry {PC, IR} trace buffer with three capture modes.
module debug_trace
  import debug_pkg::*;
#(
  parameter int NBRK  = 4,
  parameter int DEPTH = 1024,
  parameter int CW    = $clog2(DEPTH) + 1,
  parameter int SW    = (NBRK > 1) ? $clog2(NBRK) : 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [0:35]      cpuADDR,
  input  logic [18:35]     cpuPC,
  input  logic [0:35]      cpuHR,
  input  logic             regsLOAD,
  input  logic [NBRK*36-1:0] brkBAR,
  input  logic [NBRK*36-1:0] brkBMR,
  input  logic [NBRK-1:0]  brkEN,
  input  logic             brkCLR,
  input  logic [1:0]       trMODE,
  input  logic [SW-1:0]    trSEL,
  input  logic [CW-1:0]    trPOST,
  input  logic             trRESET,
  input  logic             trREAD,
  output logic [0:63]      debugITR,
  output logic [CW-1:0]    trCOUNT,
  output logic             trEMPTY,
  output logic             trFULL,
  output logic [2:0]       trSTATE,
  output logic [NBRK-1:0]  brkHIT,
  output logic             debugHALT
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW-1:0] PTR_ONE  = {{(AW-1){1'b0}}, 1'b1};
  localparam logic [CW-1:0] CNT_ONE  = {{(CW-1){1'b0}}, 1'b1};
  localparam logic [CW-1:0] CNT_ZERO = {CW{1'b0}};
  localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);

  tr_state_e       state_r;
  logic [1:0]      mode_r;
  logic [AW-1:0]   wptr_r, rptr_r;
  logic [CW-1:0]   cnt_r, post_r, cnt_next_s;
  logic            empty_r, full_r, halt_r;
  logic [NBRK-1:0] hit_r, match_s, hit_next_s;
  logic            trig_s, rd_s, wr_s, wr_en_s, ovw_s;
  logic [53:0]     rdata_s;

  // Comparators, trigger selection and next sticky-hit value
  always_comb begin
    match_s = {NBRK{1'b0}};
    trig_s  = 1'b0;
    for (int i = 0; i < NBRK; i++) begin
      match_s[i] = brkEN[i] &
                   ((cpuADDR & brkBMR[36*i +: 36]) == (brkBAR[36*i +: 36] & brkBMR[36*i +: 36]));
      if (trSEL == SW'(i)) begin
        trig_s = match_s[i];
      end else begin
        trig_s = trig_s;
      end
    end
    if (brkCLR) begin
      hit_next_s = match_s;
    end else begin
      hit_next_s = hit_r | match_s;
    end
  end

  // Buffer read/write qualification and next occupancy
  always_comb begin
    case (state_r)
      ST_ARMED: wr_s = regsLOAD & trig_s;
      ST_ACQ:   wr_s = regsLOAD & ((mode_r == TR_STOP) | ~full_r);
      ST_POST:  wr_s = regsLOAD;
      default:  wr_s = 1'b0;
    endcase
    rd_s    = trREAD & ~empty_r & ~trRESET;
    wr_en_s = wr_s & (trMODE != TR_OFF) & ~trRESET;
    // A write into a full circular buffer with no pop retires the oldest entry
    ovw_s   = wr_en_s & full_r & ~rd_s;
    if (ovw_s) begin
      cnt_next_s = cnt_r;
    end else begin
      cnt_next_s = cnt_r + {{(CW-1){1'b0}}, wr_en_s} - {{(CW-1){1'b0}}, rd_s};
    end
  end

  // Sticky breakpoint hits and halt request
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      hit_r  <= {NBRK{1'b0}};
      halt_r <= 1'b0;
    end else begin
      hit_r  <= hit_next_s;
      halt_r <= |hit_next_s;
    end
  end

  // Trace FSM, pointers and occupancy
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r <= ST_IDLE;
      mode_r  <= TR_OFF;
      wptr_r  <= {AW{1'b0}};
      rptr_r  <= {AW{1'b0}};
      cnt_r   <= CNT_ZERO;
      post_r  <= CNT_ZERO;
      empty_r <= 1'b1;
      full_r  <= 1'b0;
    end else if (trRESET) begin
      state_r <= ST_IDLE;
      wptr_r  <= {AW{1'b0}};
      rptr_r  <= {AW{1'b0}};
      cnt_r   <= CNT_ZERO;
      post_r  <= CNT_ZERO;
      empty_r <= 1'b1;
      full_r  <= 1'b0;
    end else begin
      if (wr_en_s) wptr_r <= wptr_r + PTR_ONE;
      if (rd_s | ovw_s) rptr_r <= rptr_r + PTR_ONE;
      cnt_r   <= cnt_next_s;
      empty_r <= (cnt_next_s == CNT_ZERO);
      full_r  <= (cnt_next_s == FULL_CNT);
      if (trMODE == TR_OFF) begin
        state_r <= ST_IDLE;
      end else begin
        case (state_r)
          ST_IDLE: begin
            mode_r  <= trMODE;
            state_r <= (trMODE == TR_START) ? ST_ARMED : ST_ACQ;
          end
          ST_ARMED: if (trig_s) state_r <= ST_ACQ;
          ST_ACQ: begin
            if (mode_r == TR_STOP) begin
              if (trig_s) begin
                post_r  <= trPOST;
                state_r <= (trPOST == CNT_ZERO) ? ST_DONE : ST_POST;
              end
            end else if (cnt_next_s == FULL_CNT) begin
              state_r <= ST_DONE;
            end
          end
          ST_POST: begin
            if (regsLOAD) begin
              post_r <= post_r - CNT_ONE;
              if (post_r <= CNT_ONE) state_r <= ST_DONE;
            end
          end
          ST_DONE: state_r <= ST_DONE;
          default: state_r <= ST_IDLE;
        endcase
      end
    end
  end

  trace_ram #(.DEPTH(DEPTH), .WIDTH(54)) u_ram (
    .clk   (clk),
    .rst   (rst),
    .we    (wr_en_s),
    .waddr (wptr_r),
    .wdata ({cpuPC, cpuHR}),
    .re    (rd_s),
    .raddr (rptr_r),
    .rdata (rdata_s)
  );

  assign debugITR  = pack_itr(rdata_s[53:36], rdata_s[35:0]);
  assign trCOUNT   = cnt_r;
  assign trEMPTY   = empty_r;
  assign trFULL    = full_r;
  assign trSTATE   = state_r;
  assign brkHIT    = hit_r;
  assign debugHALT = halt_r;

endmodule
